// File: rtl/hazard_controller_if.sv
// Pipeline-hazard bundle between the five-stage datapath and the hazard controller.
// The datapath side is master (drives register ids and stage status), the controller side is slave.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  logic             RegWriteM;
  logic             RegWriteW;
  logic [1:0]       ResultSrcE;
  logic [1:0]       ResultSrcM;
  logic [1:0]       PCSrcE;
  logic             MemReqM;
  logic             MemReadyM;

  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, PCSrcE,
    output MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, PCSrcE,
    input  MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard unit for the five-stage RISC-V pipeline: operand forwarding, load-use stall,
// branch flush, data-memory wait freeze with timeout halt, and saturating stall/flush counters.
module hazard_controller #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_controller_if.slave hz
);

  localparam int              WC_W    = $clog2(TIMEOUT + 1);
  // A busy cycle seen with the counter here would bring it to TIMEOUT.
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lw_stall;
  logic redirect;
  logic mem_busy;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  function automatic logic [1:0] fwd_select(
    input logic [4:0] rs,
    input logic       rw_m,
    input logic [4:0] rd_m,
    input logic [1:0] src_m,
    input logic       rw_w,
    input logic [4:0] rd_w
  );
    logic       m_hit;
    logic       w_hit;
    logic [1:0] sel;
    m_hit = rw_m && (rd_m != 5'd0) && (rd_m == rs);
    w_hit = rw_w && (rd_w != 5'd0) && (rd_w == rs);
    sel   = 2'b00;
    // Loads and PC+4 in M are never taken from M; the load-use stall puts them in W first.
    if (m_hit && (src_m == 2'b00)) begin
      sel = 2'b10;
    end else if (m_hit && (src_m == 2'b11)) begin
      sel = 2'b11;
    end else if (w_hit) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  logic [1:0][4:0] rs_e;
  logic [1:0][1:0] fwd_sel;

  assign rs_e = {hz.Rs2E, hz.Rs1E};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] = fwd_select(rs_e[gi], hz.RegWriteM, hz.RdM, hz.ResultSrcM,
                                      hz.RegWriteW, hz.RdW);
    end
  endgenerate

  assign lw_stall = ((hz.ResultSrcE == 2'b01) || (hz.ResultSrcE == 2'b10)) &&
                    (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign redirect = (hz.PCSrcE != 2'b00);
  assign mem_busy = hz.MemReqM && !hz.MemReadyM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (mem_busy) begin
          state_d = S_WAIT;
          wait_d  = WC_W'(1);
        end
      end
      S_WAIT: begin
        if (!mem_busy) begin
          state_d = S_RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q >= WC_LAST) begin
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RUN;
        wait_d  = '0;
      end
    endcase

    // Controls are held inactive for as long as reset is asserted, not just from the next edge.
    if (rst) begin
      if ((state_q == S_HALT) || mem_busy) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (redirect) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((stall_f || stall_d || stall_e || stall_m) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if ((flush_d || flush_e) && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  assign hz.ForwardAE = rst ? fwd_sel[0] : 2'b00;
  assign hz.ForwardBE = rst ? fwd_sel[1] : 2'b00;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.mem_err   = (state_q == S_HALT);
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: expected outputs are queued as each step is driven
// and compared once the combinational outputs have settled.
module tb_hazard_controller;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;

  // Control vector layout: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_LW     = 7'b1100010;
  localparam logic [6:0] C_REDIR  = 7'b0000110;
  localparam logic [6:0] C_FREEZE = 7'b1111001;

  typedef struct {
    string       tag;
    int          kind;
    logic [15:0] exp;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors    = 0;
  int   miscompares = 0;
  int   exp_stall  = 0;
  int   exp_flush  = 0;
  sb_item_t sb[$];

  hazard_controller_if #(.CNT_W(CNT_W)) hz_if ();

  hazard_controller #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] observe(input int kind);
    logic [15:0] v;
    case (kind)
      0:       v = {9'b0, hz_if.StallF, hz_if.StallD, hz_if.StallE, hz_if.StallM,
                    hz_if.FlushD, hz_if.FlushE, hz_if.FlushW};
      1:       v = {14'b0, hz_if.ForwardAE};
      2:       v = {14'b0, hz_if.ForwardBE};
      3:       v = {15'b0, hz_if.mem_err};
      4:       v = 16'(hz_if.stall_cnt);
      default: v = 16'(hz_if.flush_cnt);
    endcase
    return v;
  endfunction

  function automatic string sig_name(input int kind);
    case (kind)
      0:       return "ctrl";
      1:       return "ForwardAE";
      2:       return "ForwardBE";
      3:       return "mem_err";
      4:       return "stall_cnt";
      default: return "flush_cnt";
    endcase
  endfunction

  task automatic clear_in();
    hz_if.Rs1D       = 5'd0;
    hz_if.Rs2D       = 5'd0;
    hz_if.Rs1E       = 5'd0;
    hz_if.Rs2E       = 5'd0;
    hz_if.RdE        = 5'd0;
    hz_if.RdM        = 5'd0;
    hz_if.RdW        = 5'd0;
    hz_if.RegWriteM  = 1'b0;
    hz_if.RegWriteW  = 1'b0;
    hz_if.ResultSrcE = 2'b00;
    hz_if.ResultSrcM = 2'b00;
    hz_if.PCSrcE     = 2'b00;
    hz_if.MemReqM    = 1'b0;
    hz_if.MemReadyM  = 1'b0;
  endtask

  // Queue the expectation for the stimulus just driven, let it settle, then drain and compare.
  // The counter model advances as the coming rising edge will count this cycle.
  task automatic chk(input string tag, input logic [6:0] ectrl,
                     input logic [1:0] efa, input logic [1:0] efb, input logic eerr);
    sb_item_t    it;
    logic [15:0] obs;
    sb.push_back('{tag, 0, {9'b0, ectrl}});
    sb.push_back('{tag, 1, {14'b0, efa}});
    sb.push_back('{tag, 2, {14'b0, efb}});
    sb.push_back('{tag, 3, {15'b0, eerr}});
    sb.push_back('{tag, 4, 16'(exp_stall)});
    sb.push_back('{tag, 5, 16'(exp_flush)});
    #1;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = observe(it.kind);
      vectors++;
      assert (obs === it.exp) else begin
        miscompares++;
        $error("FAIL %s/%s: observed %0h expected %0h", it.tag, sig_name(it.kind), obs, it.exp);
      end
    end
    if (rst && (|ectrl[6:3])) exp_stall = (exp_stall >= MAXC) ? MAXC : exp_stall + 1;
    if (rst && (ectrl[2] | ectrl[1])) exp_flush = (exp_flush >= MAXC) ? MAXC : exp_flush + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk);
    rst = 1'b1;
    clear_in();
  endtask

  initial begin
    clear_in();
    // Hazardous inputs while in reset: every control must still read inactive.
    hz_if.RegWriteM = 1'b1; hz_if.RdM = 5'd5; hz_if.Rs1E = 5'd5;
    hz_if.MemReqM = 1'b1;   hz_if.PCSrcE = 2'b01;
    @(negedge clk);
    chk("reset", C_NONE, 2'b00, 2'b00, 1'b0);
    rst = 1'b1;
    clear_in();

    // Forwarding priority
    @(negedge clk);
    hz_if.RegWriteM = 1'b1; hz_if.RdM = 5'd5; hz_if.ResultSrcM = 2'b00;
    hz_if.RegWriteW = 1'b1; hz_if.RdW = 5'd5; hz_if.Rs1E = 5'd5; hz_if.Rs2E = 5'd5;
    chk("fwd_alu_m", C_NONE, 2'b10, 2'b10, 1'b0);
    @(negedge clk); hz_if.ResultSrcM = 2'b11;
    chk("fwd_imm_m", C_NONE, 2'b11, 2'b11, 1'b0);
    @(negedge clk); hz_if.RegWriteM = 1'b0;
    chk("fwd_w", C_NONE, 2'b01, 2'b01, 1'b0);
    @(negedge clk); hz_if.RdW = 5'd0; hz_if.Rs2E = 5'd0;
    chk("fwd_x0", C_NONE, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    hz_if.RegWriteM = 1'b1; hz_if.ResultSrcM = 2'b01; hz_if.RdW = 5'd5; hz_if.Rs2E = 5'd9;
    chk("fwd_load_m_uses_w", C_NONE, 2'b01, 2'b00, 1'b0);
    @(negedge clk); hz_if.ResultSrcM = 2'b10; hz_if.RegWriteW = 1'b0;
    chk("fwd_pc4_m_none", C_NONE, 2'b00, 2'b00, 1'b0);
    @(negedge clk); clear_in();
    hz_if.RegWriteM = 1'b1; hz_if.RdM = 5'd0; hz_if.Rs1E = 5'd0; hz_if.Rs2E = 5'd0;
    chk("fwd_rdm_x0", C_NONE, 2'b00, 2'b00, 1'b0);

    // Load-use stall and redirect override
    @(negedge clk); clear_in();
    hz_if.ResultSrcE = 2'b01; hz_if.RdE = 5'd7; hz_if.Rs2D = 5'd7;
    chk("lw_stall", C_LW, 2'b00, 2'b00, 1'b0);
    @(negedge clk); hz_if.ResultSrcE = 2'b00;
    chk("lw_bubble", C_NONE, 2'b00, 2'b00, 1'b0);
    @(negedge clk); hz_if.ResultSrcE = 2'b10; hz_if.Rs1D = 5'd7; hz_if.Rs2D = 5'd0;
    chk("pc4_stall", C_LW, 2'b00, 2'b00, 1'b0);
    @(negedge clk); hz_if.RdE = 5'd0; hz_if.Rs1D = 5'd0;
    chk("lw_rd_x0", C_NONE, 2'b00, 2'b00, 1'b0);
    @(negedge clk); hz_if.ResultSrcE = 2'b01; hz_if.RdE = 5'd7; hz_if.Rs2D = 5'd7;
    hz_if.PCSrcE = 2'b01;
    chk("redir_over_lw", C_REDIR, 2'b00, 2'b00, 1'b0);
    @(negedge clk); clear_in();
    chk("after_redir", C_NONE, 2'b00, 2'b00, 1'b0);

    // Memory wait of three cycles, released on the ready cycle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); hz_if.MemReqM = 1'b1; hz_if.MemReadyM = 1'b0;
      chk($sformatf("mem_wait%0d", i), C_FREEZE, 2'b00, 2'b00, 1'b0);
    end
    @(negedge clk); hz_if.MemReadyM = 1'b1;
    chk("mem_ready", C_NONE, 2'b00, 2'b00, 1'b0);
    @(negedge clk); clear_in();
    chk("mem_done", C_NONE, 2'b00, 2'b00, 1'b0);

    // Freeze dominates redirect and load-use; forwarding stays live
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      hz_if.MemReqM = 1'b1; hz_if.MemReadyM = 1'b0; hz_if.PCSrcE = 2'b10;
      hz_if.ResultSrcE = 2'b01; hz_if.RdE = 5'd3; hz_if.Rs1D = 5'd3;
      hz_if.RegWriteW = 1'b1; hz_if.RdW = 5'd4; hz_if.Rs2E = 5'd4;
      chk($sformatf("freeze_redir%0d", i), C_FREEZE, 2'b00, 2'b01, 1'b0);
    end
    @(negedge clk); hz_if.MemReadyM = 1'b1;
    chk("release_redir", C_REDIR, 2'b00, 2'b01, 1'b0);
    @(negedge clk); clear_in();
    chk("release_done", C_NONE, 2'b00, 2'b00, 1'b0);

    // Timeout into HALT, then asynchronous reset out of it
    do_reset();
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk); hz_if.MemReqM = 1'b1; hz_if.MemReadyM = 1'b0;
      chk($sformatf("to_wait%0d", i), C_FREEZE, 2'b00, 2'b00, 1'b0);
    end
    @(negedge clk); hz_if.MemReadyM = 1'b1;
    chk("halt_ready", C_FREEZE, 2'b00, 2'b00, 1'b1);
    @(negedge clk); hz_if.MemReqM = 1'b0; hz_if.PCSrcE = 2'b01;
    hz_if.RegWriteM = 1'b1; hz_if.RdM = 5'd5; hz_if.Rs1E = 5'd5;
    chk("halt_sticky", C_FREEZE, 2'b10, 2'b00, 1'b1);
    #2;
    rst = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    chk("async_rst_halt", C_NONE, 2'b00, 2'b00, 1'b0);
    @(negedge clk); rst = 1'b1; clear_in();
    chk("run_after_rst", C_NONE, 2'b00, 2'b00, 1'b0);
    @(negedge clk); hz_if.MemReqM = 1'b1;
    chk("run_busy", C_FREEZE, 2'b00, 2'b00, 1'b0);
    @(negedge clk); hz_if.MemReadyM = 1'b1;
    chk("run_ready", C_NONE, 2'b00, 2'b00, 1'b0);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); hz_if.ResultSrcE = 2'b01; hz_if.RdE = 5'd7; hz_if.Rs2D = 5'd7;
      chk($sformatf("sat%0d", i), C_LW, 2'b00, 2'b00, 1'b0);
    end
    @(negedge clk); clear_in();
    chk("sat_hold", C_NONE, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    chk("sat_hold2", C_NONE, 2'b00, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Sequences the five-stage RISC-V pipeline.
- Generates forwarding selects, stall and flush controls, and a data-memory wait freeze for a variable-latency data memory.
- Holds a memory-wait FSM with timeout and saturating performance counters.
- Sits beside the pipelined datapath and drives its StallF/StallD/StallE/StallM/FlushD/FlushE/FlushW and ForwardAE/ForwardBE inputs.

Parameters:
- TIMEOUT, 64: max consecutive memory-wait cycles before error halt (>=2).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Rs1D, Rs2D  in  5  decode source registers.
- Rs1E, Rs2E, RdE  in  5  execute source/destination registers.
- RdM, RdW  in  5  memory/writeback destination registers.
- RegWriteM, RegWriteW  in  1  register-write enables.
- ResultSrcE, ResultSrcM  in  2  result select; 00 ALU, 01 load, 10 PC+4, 11 ExtImm.
- PCSrcE  in  2  PC select; nonzero = redirect.
- MemReqM  in  1  load/store in M.
- MemReadyM  in  1  data memory done.
- ForwardAE, ForwardBE  out  2  00 RD, 01 ResultW, 10 ALUResultM, 11 ExtImmM.
- StallF, StallD, StallE, StallM  out  1  hold stage register.
- FlushD, FlushE, FlushW  out  1  insert bubble.
- mem_err  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  saturating counters.

Behaviour:
- Forwarding (comb, per operand X in {A,B}, source RsXE):
  - 10 if RegWriteM, RdM!=0, RdM==RsXE and ResultSrcM==00.
  - Else 11 under the same match with ResultSrcM==11.
  - Else 01 if RegWriteW, RdW!=0, RdW==RsXE.
  - Else 00.
  - M has priority over W.
  - ResultSrcM 01/10 never forwards from M; the load-use stall guarantees that producer is in W.
- lwStall = (ResultSrcE==01 or 10) and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- redirect = PCSrcE!=00.
- mem_busy = MemReqM and !MemReadyM.
- FSM states RUN, WAIT, HALT. Reset state RUN, wait counter 0.
  - RUN: if mem_busy -> WAIT, counter=1.
  - WAIT: mem_busy -> stay, counter+1; if the counter would reach TIMEOUT -> HALT. !mem_busy -> RUN, counter=0.
  - HALT: terminal until reset; mem_err=1.
- Output priority, highest first:
  1. HALT: StallF/D/E/M=1, FlushW=1, other flushes 0.
  2. freeze = mem_busy (any non-HALT state, combinational on MemReadyM): StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0. A pending redirect or lwStall is re-evaluated after release, since the E instruction is held.
  3. redirect: FlushD=1, FlushE=1, StallF=StallD=0. Overrides a simultaneous lwStall, because the stalled instruction is discarded.
  4. lwStall: StallF=StallD=1, FlushE=1.
  5. Otherwise all stall/flush outputs 0.
- Forward selects stay live during a freeze.
- Completion cycle: when MemReadyM rises, that same cycle is unfrozen and the pipeline advances.
- Counters:
  - stall_cnt +1 on each cycle with any Stall* high.
  - flush_cnt +1 on each cycle with FlushD or FlushE high.
  - Both saturate at 2^CNT_W-1; no wrap.
- Reset (rst=0, asynchronous):
  - State RUN; counters 0; mem_err 0.
  - All stall/flush outputs forced 0; Forward* forced 00.
  - Mid-WAIT or HALT reset returns to RUN immediately.

Test Plan:
- ALU forwarding: RegWriteM=1, RdM=5, ResultSrcM=00, Rs1E=5, RegWriteW=1, RdW=5, Rs2E=5 -> ForwardAE=10, ForwardBE=10. Then ResultSrcM=11 -> 11. Then RegWriteM=0 -> 01. Then RdW=0 with Rs2E=0 -> ForwardBE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7, PCSrcE=00 -> StallF=StallD=FlushE=1 for exactly one cycle, stall_cnt+1. Same with PCSrcE=01 -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> StallF/D/E/M=1 and FlushW=1 for 3 cycles, 0 on the ready cycle. State returns to RUN, stall_cnt+3.
- Freeze dominates redirect: PCSrcE=10 during mem_busy -> FlushD=FlushE=0. After ready with PCSrcE still 10 -> FlushD=FlushE=1, flush_cnt+1.
- Timeout: TIMEOUT=4, MemReadyM held 0 -> HALT entered after the 4th wait cycle, mem_err=1, stalls stuck high even after MemReadyM=1. rst=0 mid-HALT -> all outputs 0 asynchronously, mem_err=0.
- Saturation: CNT_W=4, 20 consecutive lwStall cycles -> stall_cnt=15 and holds.
